// File: rtl/microwave_timer.sv
// BCD MM:SS countdown timer for the microwave controller: keypad entry while idle,
// one-second countdown while the heating latch is set, and done level/pulse back to control.
module microwave_timer #(
  parameter int unsigned CLK_PER_SEC = 50_000_000,
  parameter int unsigned PRESC_W     = 26
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clearn,
  input  logic       load,
  input  logic [3:0] digit,
  input  logic       enable,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       timer_done,
  output logic       done_pulse,
  output logic       running
);

  localparam int unsigned DIGIT_W = 4;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_PER_SEC - 1);

  logic [DIGIT_W-1:0] min_tens_q, min_tens_d;
  logic [DIGIT_W-1:0] min_ones_q, min_ones_d;
  logic [DIGIT_W-1:0] sec_tens_q, sec_tens_d;
  logic [DIGIT_W-1:0] sec_ones_q, sec_ones_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               done_q, done_d;
  logic               pulse_q, pulse_d;
  logic               count_zero_c;
  logic               load_ok_c;

  assign count_zero_c = ({min_tens_q, min_ones_q, sec_tens_q, sec_ones_q} == 16'h0000);
  assign load_ok_c    = load && !enable && (digit <= 4'd9);

  // Next-state: clear > valid digit entry > countdown / zero-start detection
  always_comb begin
    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    presc_d    = presc_q;
    done_d     = done_q;

    if (!clearn) begin
      min_tens_d = '0;
      min_ones_d = '0;
      sec_tens_d = '0;
      sec_ones_d = '0;
      presc_d    = '0;
      done_d     = 1'b0;
    end else if (load_ok_c) begin
      min_tens_d = min_ones_q;
      min_ones_d = sec_tens_q;
      sec_tens_d = sec_ones_q;
      sec_ones_d = digit;
      presc_d    = '0;
      done_d     = 1'b0;
    end else if (enable && !done_q) begin
      if (count_zero_c) begin
        done_d = 1'b1;
      end else if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        // Borrow normalises seconds-tens to 5, so entries like 0:90 count down naturally
        if (sec_ones_q != 4'd0) begin
          sec_ones_d = sec_ones_q - 4'd1;
        end else begin
          sec_ones_d = 4'd9;
          if (sec_tens_q != 4'd0) begin
            sec_tens_d = sec_tens_q - 4'd1;
          end else begin
            sec_tens_d = 4'd5;
            if (min_ones_q != 4'd0) begin
              min_ones_d = min_ones_q - 4'd1;
            end else begin
              min_ones_d = 4'd9;
              min_tens_d = min_tens_q - 4'd1;
            end
          end
        end
        if ({min_tens_d, min_ones_d, sec_tens_d, sec_ones_d} == 16'h0000) begin
          done_d = 1'b1;
        end
      end else begin
        presc_d = presc_q + PRESC_W'(1);
      end
    end

    pulse_d = done_d && !done_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      min_tens_q <= '0;
      min_ones_q <= '0;
      sec_tens_q <= '0;
      sec_ones_q <= '0;
      presc_q    <= '0;
      done_q     <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      min_tens_q <= min_tens_d;
      min_ones_q <= min_ones_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
      presc_q    <= presc_d;
      done_q     <= done_d;
      pulse_q    <= pulse_d;
    end
  end

  assign min_tens   = min_tens_q;
  assign min_ones   = min_ones_q;
  assign sec_tens   = sec_tens_q;
  assign sec_ones   = sec_ones_q;
  assign timer_done = done_q;
  assign done_pulse = pulse_q;
  assign running    = enable && !done_q && !count_zero_c;

endmodule

// File: tb/tb_microwave_timer.sv
// Directed bench for microwave_timer with CLK_PER_SEC=4; expected display/flag values
// are queued as stimulus is applied and checked when the DUT output is sampled.
module tb_microwave_timer;

  logic       clk;
  logic       resetn;
  logic       clearn;
  logic       load;
  logic [3:0] digit;
  logic       enable;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       timer_done, done_pulse, running;

  int n_total;
  int n_pass;

  typedef struct {
    string       tag;
    logic [15:0] digits;
    logic        done;
    logic        pulse;
    logic        run;
  } exp_t;

  exp_t sb_q[$];

  microwave_timer #(.CLK_PER_SEC(4), .PRESC_W(3)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .clearn     (clearn),
    .load       (load),
    .digit      (digit),
    .enable     (enable),
    .min_tens   (min_tens),
    .min_ones   (min_ones),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .timer_done (timer_done),
    .done_pulse (done_pulse),
    .running    (running)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
  endtask

  // Pop the oldest expectation and compare it against the current outputs
  task automatic check_sb();
    exp_t e;
    if (sb_q.size() == 0) begin
      cmp("scoreboard_empty", 16'd0, 16'd1);
      return;
    end
    e = sb_q.pop_front();
    cmp({e.tag, ".digits"}, {min_tens, min_ones, sec_tens, sec_ones}, e.digits);
    cmp({e.tag, ".done"},   16'(timer_done), 16'(e.done));
    cmp({e.tag, ".pulse"},  16'(done_pulse), 16'(e.pulse));
    cmp({e.tag, ".run"},    16'(running),    16'(e.run));
  endtask

  task automatic push(input string tag, input logic [15:0] d,
                      input logic dn, input logic pl, input logic rn);
    exp_t e;
    e.tag = tag; e.digits = d; e.done = dn; e.pulse = pl; e.run = rn;
    sb_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic step(input int n, input string tag, input logic [15:0] d,
                      input logic dn, input logic pl, input logic rn);
    push(tag, d, dn, pl, rn);
    tick(n);
    check_sb();
  endtask

  task automatic load_digit(input logic [3:0] dg);
    load  = 1'b1;
    digit = dg;
    tick(1);
    load  = 1'b0;
    digit = 4'd0;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    resetn  = 1'b1;
    clearn  = 1'b1;
    load    = 1'b0;
    digit   = 4'd0;
    enable  = 1'b0;

    #2 resetn = 1'b0;
    push("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    #1 check_sb();
    @(negedge clk) resetn = 1'b1;
    tick(1);

    // Entry 00:03 and countdown
    load_digit(4'd0); load_digit(4'd0); load_digit(4'd0);
    step(0, "entry3", 16'h0000, 1'b0, 1'b0, 1'b0);
    load_digit(4'd3);
    step(0, "entry3_done", 16'h0003, 1'b0, 1'b0, 1'b0);
    enable = 1'b1;
    step(3, "cnt_presc3", 16'h0003, 1'b0, 1'b0, 1'b1);
    step(1, "cnt_0002",   16'h0002, 1'b0, 1'b0, 1'b1);
    step(4, "cnt_0001",   16'h0001, 1'b0, 1'b0, 1'b1);
    step(4, "cnt_0000",   16'h0000, 1'b1, 1'b1, 1'b0);
    step(1, "pulse_drop", 16'h0000, 1'b1, 1'b0, 1'b0);
    enable = 1'b0;
    step(1, "done_holds", 16'h0000, 1'b1, 1'b0, 1'b0);

    // Load after completion clears done, then borrow chain 10:00 -> 09:59
    load_digit(4'd1);
    step(0, "load_clr_done", 16'h0001, 1'b0, 1'b0, 1'b0);
    load_digit(4'd0); load_digit(4'd0); load_digit(4'd0);
    step(0, "entry1000", 16'h1000, 1'b0, 1'b0, 1'b0);
    enable = 1'b1;
    step(4, "borrow_0959", 16'h0959, 1'b0, 1'b0, 1'b1);
    step(4, "borrow_0958", 16'h0958, 1'b0, 1'b0, 1'b1);
    enable = 1'b0;

    // Pause/resume keeps partial second; ignored loads
    clearn = 1'b0;
    step(1, "clear1", 16'h0000, 1'b0, 1'b0, 1'b0);
    clearn = 1'b1;
    load_digit(4'd0); load_digit(4'd0); load_digit(4'd0); load_digit(4'd5);
    enable = 1'b1;
    step(6, "pause_pre", 16'h0004, 1'b0, 1'b0, 1'b1);
    enable = 1'b0;
    step(10, "paused", 16'h0004, 1'b0, 1'b0, 1'b0);
    enable = 1'b1;
    step(2, "resumed", 16'h0003, 1'b0, 1'b0, 1'b1);
    load = 1'b1; digit = 4'd7;
    step(1, "load_while_en", 16'h0003, 1'b0, 1'b0, 1'b1);
    load = 1'b0; enable = 1'b0;
    load = 1'b1; digit = 4'd12;
    step(1, "load_bad_digit", 16'h0003, 1'b0, 1'b0, 1'b0);
    load = 1'b0; digit = 4'd0;

    // Zero start and clear
    clearn = 1'b0;
    step(1, "clear2", 16'h0000, 1'b0, 1'b0, 1'b0);
    clearn = 1'b1;
    enable = 1'b1;
    step(1, "zero_start", 16'h0000, 1'b1, 1'b1, 1'b0);
    step(1, "zero_hold",  16'h0000, 1'b1, 1'b0, 1'b0);
    clearn = 1'b0;
    enable = 1'b0;
    step(1, "clear_done", 16'h0000, 1'b0, 1'b0, 1'b0);
    clearn = 1'b1;

    // Async reset mid-count
    load_digit(4'd0); load_digit(4'd0); load_digit(4'd0); load_digit(4'd3);
    enable = 1'b1;
    step(4, "pre_reset", 16'h0002, 1'b0, 1'b0, 1'b1);
    #2 resetn = 1'b0;
    push("async_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    #1 check_sb();
    #2 resetn = 1'b1;
    step(1, "post_reset_zero", 16'h0000, 1'b1, 1'b1, 1'b0);
    enable = 1'b0;

    // Clear collides with final decrement
    clearn = 1'b0;
    tick(1);
    clearn = 1'b1;
    load_digit(4'd0); load_digit(4'd0); load_digit(4'd0); load_digit(4'd1);
    enable = 1'b1;
    step(3, "pre_final", 16'h0001, 1'b0, 1'b0, 1'b1);
    clearn = 1'b0;
    step(1, "clear_wins", 16'h0000, 1'b0, 1'b0, 1'b0);
    clearn = 1'b1;
    enable = 1'b0;
    step(1, "no_pulse", 16'h0000, 1'b0, 1'b0, 1'b0);

    cmp("sb_drained", 16'(sb_q.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/microwave_timer.md
Name: microwave_timer

Overview:
- BCD countdown timer (MM:SS) for the microwave oven controller.
- Takes keypad digit entry while idle, counts down once per second while the heating latch output (enable) is high, and drives timer_done back into the control logic.
- Also provides the four display digits.
- Sits between the keypad/display and the S/R control logic: it consumes the latch output and produces the stop condition.

Parameters:
- CLK_PER_SEC, 50_000_000: clock cycles per one-second countdown step; minimum 2.
- PRESC_W, 26: prescaler counter width; must hold CLK_PER_SEC-1.

Ports:
- clk  input  1  system clock, rising edge
- resetn  input  1  asynchronous active-low reset
- clearn  input  1  synchronous active-low clear (keypad CLEAR button)
- load  input  1  one-cycle strobe: digit is valid
- digit  input  4  BCD keypad digit
- enable  input  1  heating latch output; high = counting allowed
- min_tens  output  4  BCD display digit
- min_ones  output  4  BCD display digit
- sec_tens  output  4  BCD display digit
- sec_ones  output  4  BCD display digit
- timer_done  output  1  level; high = countdown finished or started at zero
- done_pulse  output  1  one-cycle pulse when timer_done rises (buzzer)
- running  output  1  high while actively counting (enable & !timer_done & count != 0)

Behaviour:
- Reset (resetn=0, asynchronous):
  - All digits 0, timer_done=0, done_pulse=0, prescaler=0.
  - running is combinational, so it is 0 during reset.
- Priority each rising edge, highest first: clearn=0 > load > countdown.
- clearn=0:
  - All digits 0, prescaler 0, timer_done 0, done_pulse 0.
  - Applies regardless of enable.
- Digit entry: load=1 and enable=0 and digit<=9.
  - Shift left: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=digit.
  - prescaler<=0, timer_done<=0.
  - The old min_tens is discarded.
- Ignored loads:
  - load with digit>9 is ignored entirely.
  - load while enable=1 is ignored; the count cannot be edited while heating.
- Entered sec_tens may be 6..9 (e.g. 0:90 = 90 s). Countdown decrements it normally; normalisation happens only on borrow.
- Countdown: enable=1 and timer_done=0 and count!=0000.
  - Prescaler increments each cycle.
  - When it equals CLK_PER_SEC-1 it returns to 0 and the count decrements by one second, in the same edge.
- BCD decrement rules:
  - sec_ones>0: sec_ones-1.
  - Otherwise sec_ones=9, and sec_tens>0: sec_tens-1.
  - Otherwise sec_tens=5, and min_ones>0: min_ones-1.
  - Otherwise min_ones=9, min_tens-1.
  - Example: 10:00 -> 09:59.
  - Decrement from 0000 never occurs.
- Completion: when a decrement produces 0000, timer_done<=1 on that same edge, and done_pulse=1 for exactly that cycle.
- Start at zero: enable=1 while count==0000 and timer_done=0 sets timer_done=1 on the next edge, with done_pulse for one cycle. This blocks starting an empty timer.
- timer_done holds at 1 until clearn=0, a valid load, or reset. It does not clear when enable drops.
- Pause (enable falls mid-count):
  - Digits and prescaler hold; the partial second is retained.
  - Resume continues from the held prescaler value.
- done_pulse is registered, high only on the cycle after the rising transition of timer_done.
- Simultaneous events:
  - clearn=0 with the final decrement edge: the clear wins; timer_done stays 0, no pulse.
  - load and enable rising on the same edge: the load is honoured (enable sampled 0 that cycle is required); if enable=1 that cycle, the load is ignored.
- All outputs are registered except running.

Test Plan (CLK_PER_SEC=4):
- Entry and 3 s countdown:
  - Stimulus: resetn pulse, load digits 0,0,0,3, enable=1.
  - Display 00:03 after entry.
  - Display 00:02 after 4 cycles, 00:01 after 8, 00:00 after 12.
  - timer_done=1 and done_pulse=1 on the 12th edge; done_pulse=0 on the 13th.
- Borrow chain:
  - Stimulus: load 1,0,0,0 (10:00), enable=1 for 4 cycles.
  - Display 09:59.
  - Continuing 4 more cycles gives 09:58.
- Pause/resume and ignored loads:
  - Load 0,0,0,5, enable=1 for 6 cycles -> display 00:04 with prescaler=2.
  - enable=0 for 10 cycles -> digits unchanged.
  - enable=1 for 2 cycles -> display 00:03.
  - load while enable=1 -> no change.
  - load digit=12 while idle -> no change.
- Zero start and clear:
  - Stimulus: enable=1 with count 0000.
  - timer_done=1 next edge, with done_pulse.
  - Then clearn=0 for 1 cycle -> timer_done=0, digits 0.
  - A load after a completed run also clears timer_done.
- Async reset mid-count:
  - Stimulus: at 00:02 with enable=1, assert resetn=0 between edges.
  - Outputs go to 0 immediately, without a clock edge.
  - After release with enable=1 and count 0, timer_done sets next edge.
- Clear vs final decrement:
  - Stimulus: clearn=0 on the edge that would reach 0000.
  - Digits 0, timer_done=0, done_pulse never asserted.
